// File: rtl/save_state_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : save_state_writer_if
// Description : APF start handshake, savestate-manager bus and PSRAM write
//               port of the save_state_writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface save_state_writer_if;
    logic        savestate_start;
    logic        savestate_start_ack;
    logic        savestate_start_busy;
    logic        savestate_start_ok;
    logic        savestate_start_err;
    logic        ss_save;
    logic [63:0] ss_din;
    logic [25:0] ss_addr;
    logic        ss_rnw;
    logic        ss_req;
    logic [7:0]  ss_be;
    logic        ss_ack;
    logic        ss_busy;
    logic        mem_write_en;
    logic [20:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_write_high_byte;
    logic        mem_write_low_byte;
    logic        mem_write_done;
    logic [31:0] save_size;
    logic [31:0] save_checksum;

    modport master (
        output savestate_start, ss_din, ss_addr, ss_rnw, ss_req, ss_be, ss_busy,
               mem_write_done,
        input  savestate_start_ack, savestate_start_busy, savestate_start_ok,
               savestate_start_err, ss_save, ss_ack, mem_write_en, mem_addr,
               mem_data, mem_write_high_byte, mem_write_low_byte, save_size,
               save_checksum
    );

    modport slave (
        input  savestate_start, ss_din, ss_addr, ss_rnw, ss_req, ss_be, ss_busy,
               mem_write_done,
        output savestate_start_ack, savestate_start_busy, savestate_start_ok,
               savestate_start_err, ss_save, ss_ack, mem_write_en, mem_addr,
               mem_data, mem_write_high_byte, mem_write_low_byte, save_size,
               save_checksum
    );
endinterface
`default_nettype wire

// File: rtl/save_state_writer.sv
`default_nettype none
// ============================================================================
// Module      : save_state_writer
// Description : Save-direction savestate controller; splits 64-bit manager
//               writes into 16-bit PSRAM words. Optional SAVE_STATE_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module save_state_writer #(
    parameter int SS_SAVE_PULSE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES       = 2**20
) (
    input  logic                 clk_ppu_21_47,
    input  logic                 reset,
    save_state_writer_if.slave   bus
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PW = $clog2(SS_SAVE_PULSE_CYCLES + 2) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ACK, S_PULSE, S_WAIT_REQ, S_WORD,
        S_WAIT_DONE, S_SEND, S_FINISH, S_ERROR
    } state_t;

    state_t         r_state;
    logic           r_prev_start, r_prev_busy;
    logic           r_start_ack, r_busy, r_ok, r_err, r_ss_save, r_ss_ack;
    logic [PW-1:0]  r_pulse_cnt;
    logic [TW-1:0]  r_to;
    logic [63:0]    r_din;
    logic [22:0]    r_addr;
    logic [7:0]     r_be;
    logic [1:0]     r_k;
    logic           r_mem_we, r_hi, r_lo;
    logic [20:0]    r_mem_addr;
    logic [15:0]    r_mem_data;
    logic [31:0]    r_save_size;
`ifdef SAVE_STATE_CHECKSUM_EN
    logic [31:0]    r_checksum;
`endif

    logic [15:0]    w_word;
    logic [1:0]     w_pair;
    logic [31:0]    w_end;

    assign w_word = r_din[{r_k, 4'b0000} +: 16];
    assign w_pair = r_be[{r_k, 1'b0} +: 2];
    // One past the last byte of the current 8-byte record
    assign w_end  = {6'd0, r_addr, 3'b000} + 32'd8;

    always_ff @(posedge clk_ppu_21_47 or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_prev_start <= 1'b0;
            r_prev_busy  <= 1'b0;
            r_start_ack  <= 1'b0;
            r_busy       <= 1'b0;
            r_ok         <= 1'b0;
            r_err        <= 1'b0;
            r_ss_save    <= 1'b0;
            r_ss_ack     <= 1'b0;
            r_pulse_cnt  <= '0;
            r_to         <= '0;
            r_din        <= '0;
            r_addr       <= '0;
            r_be         <= '0;
            r_k          <= '0;
            r_mem_we     <= 1'b0;
            r_hi         <= 1'b0;
            r_lo         <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_save_size  <= '0;
`ifdef SAVE_STATE_CHECKSUM_EN
            r_checksum   <= '0;
`endif
        end else begin
            r_prev_start <= bus.savestate_start;
            r_prev_busy  <= bus.ss_busy;
            case (r_state)
                S_IDLE: begin
                    if (bus.savestate_start && !r_prev_start) begin
                        r_state     <= S_ACK;
                        r_start_ack <= 1'b1;
                        r_ok        <= 1'b0;
                        r_err       <= 1'b0;
                        r_save_size <= '0;
                        r_busy      <= 1'b1;
                        r_ss_save   <= 1'b1;
                        r_pulse_cnt <= PW'(1);
                        r_to        <= '0;
`ifdef SAVE_STATE_CHECKSUM_EN
                        r_checksum  <= '0;
`endif
                    end
                end
                S_ACK: begin
                    r_start_ack <= 1'b0;
                    r_ss_save   <= (SS_SAVE_PULSE_CYCLES > 1);
                    r_pulse_cnt <= r_pulse_cnt + 1'b1;
                    r_state     <= S_PULSE;
                end
                S_PULSE: begin
                    // r_pulse_cnt counts ss_save-high cycles including the ACK cycle
                    if (r_pulse_cnt >= PW'(SS_SAVE_PULSE_CYCLES)) begin
                        r_ss_save <= 1'b0;
                        r_state   <= S_WAIT_REQ;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + 1'b1;
                    end
                end
                S_WAIT_REQ: begin
                    if (bus.ss_req && bus.ss_rnw) begin
                        r_busy   <= 1'b0;
                        r_err    <= 1'b1;
                        r_mem_we <= 1'b0;
                        r_state  <= S_ERROR;
                    end else if (bus.ss_req) begin
                        r_din   <= bus.ss_din;
                        r_addr  <= bus.ss_addr[25:3];
                        r_be    <= bus.ss_be;
                        r_k     <= 2'd0;
                        r_to    <= '0;
                        r_state <= S_WORD;
                    end else if (r_prev_busy && !bus.ss_busy) begin
                        r_busy  <= 1'b0;
                        r_ok    <= 1'b1;
                        r_state <= S_FINISH;
                    end else if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_busy   <= 1'b0;
                        r_err    <= 1'b1;
                        r_mem_we <= 1'b0;
                        r_state  <= S_ERROR;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                S_WORD: begin
                    if (w_pair == 2'b00) begin
                        if (r_k == 2'd3) begin
                            r_ss_ack <= 1'b1;
                            if (w_end > r_save_size) r_save_size <= w_end;
                            r_state  <= S_SEND;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end else begin
                        r_mem_addr <= {r_addr[18:0], r_k};
                        r_mem_data <= w_word;
                        r_hi       <= w_pair[1];
                        r_lo       <= w_pair[0];
                        r_mem_we   <= 1'b1;
                        r_state    <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.mem_write_done) begin
                        r_mem_we <= 1'b0;
`ifdef SAVE_STATE_CHECKSUM_EN
                        r_checksum <= r_checksum + {16'd0, r_mem_data};
`endif
                        if (r_k == 2'd3) begin
                            r_ss_ack <= 1'b1;
                            if (w_end > r_save_size) r_save_size <= w_end;
                            r_state  <= S_SEND;
                        end else begin
                            r_k     <= r_k + 1'b1;
                            r_state <= S_WORD;
                        end
                    end
                end
                S_SEND: begin
                    r_ss_ack <= 1'b0;
                    r_state  <= S_WAIT_REQ;
                end
                S_FINISH: r_state <= S_IDLE;
                S_ERROR:  r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.savestate_start_ack  = r_start_ack;
    assign bus.savestate_start_busy = r_busy;
    assign bus.savestate_start_ok   = r_ok;
    assign bus.savestate_start_err  = r_err;
    assign bus.ss_save              = r_ss_save;
    assign bus.ss_ack               = r_ss_ack;
    assign bus.mem_write_en         = r_mem_we;
    assign bus.mem_addr             = r_mem_addr;
    assign bus.mem_data             = r_mem_data;
    assign bus.mem_write_high_byte  = r_hi;
    assign bus.mem_write_low_byte   = r_lo;
    assign bus.save_size            = r_save_size;
`ifdef SAVE_STATE_CHECKSUM_EN
    assign bus.save_checksum        = r_checksum;
`else
    assign bus.save_checksum        = 32'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_save_state_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_save_state_writer
// Description : Self-checking bench for save_state_writer (vector table plus
//               write scoreboard and hand-written handshake sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_save_state_writer;
    localparam int c_TIMEOUT = 16;
    localparam int c_PULSE   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    save_state_writer_if bus ();

    save_state_writer #(
        .SS_SAVE_PULSE_CYCLES (c_PULSE),
        .TIMEOUT_CYCLES       (c_TIMEOUT)
    ) dut (
        .clk_ppu_21_47 (clk),
        .reset         (rst),
        .bus           (bus)
    );

    typedef struct packed {
        logic [20:0] addr;
        logic [15:0] data;
        logic        hi;
        logic        lo;
    } wr_t;

    typedef struct {
        logic [25:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
        int          nwr;
        logic [31:0] size;
    } vec_t;

    wr_t         exp_q[$];
    vec_t        vecs[6];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_writes = 0;
    logic [31:0] m_sum    = 32'd0;
    bit          resp_en  = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // PSRAM side: pops the scoreboard on each new write, answers done after 3 cycles
    initial begin : responder
        wr_t w;
        wr_t e;
        bus.mem_write_done = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && bus.mem_write_en === 1'b1) begin
                w = {bus.mem_addr, bus.mem_data, bus.mem_write_high_byte, bus.mem_write_low_byte};
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: actual=%h expected=none", w);
                    e = w;
                end else begin
                    e = exp_q.pop_front();
                    check("write", w, e);
                    m_sum = m_sum + {16'd0, e.data};
                end
                repeat (2) @(negedge clk);
                check("write_hold", {bus.mem_write_en, bus.mem_addr, bus.mem_data,
                      bus.mem_write_high_byte, bus.mem_write_low_byte}, {1'b1, e});
                bus.mem_write_done = 1'b1;
                @(negedge clk);
                bus.mem_write_done = 1'b0;
                check("write_en_drop", bus.mem_write_en, 1'b0);
            end
        end
    end

    task automatic do_start();
        int acks  = 0;
        int saves = 0;
        bit seen  = 1'b0;
        bus.savestate_start = 1'b0;
        @(negedge clk);
        bus.savestate_start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.savestate_start_ack) acks++;
            if (bus.ss_save) begin
                saves++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        check("start_ack_pulses", acks, 1);
        check("ss_save_cycles", saves, c_PULSE);
        check("flags_after_start", {bus.savestate_start_busy, bus.savestate_start_ok,
              bus.savestate_start_err}, 3'b100);
    endtask

    task automatic send_req(input vec_t v, output bit got);
        for (int k = 0; k < 4; k++) begin
            if (v.be[2*k +: 2] != 2'b00)
                exp_q.push_back({v.addr[21:3], 2'(k), v.din[16*k +: 16], v.be[2*k+1], v.be[2*k]});
        end
        bus.ss_addr = v.addr;
        bus.ss_din  = v.din;
        bus.ss_be   = v.be;
        bus.ss_rnw  = 1'b0;
        bus.ss_req  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ss_ack) begin
                got = 1'b1;
                break;
            end
        end
        bus.ss_req = 1'b0;
    endtask

    task automatic wait_busy_low(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.savestate_start_busy) begin
                got = 1'b1;
                break;
            end
        end
        check(name, got, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {bus.savestate_start_ack, bus.savestate_start_busy,
              bus.savestate_start_ok, bus.savestate_start_err, bus.ss_save, bus.ss_ack,
              bus.mem_write_en, bus.mem_write_high_byte, bus.mem_write_low_byte}, 9'd0);
        check({tag, "_mem"}, {bus.mem_addr, bus.mem_data}, 37'd0);
        check({tag, "_size"}, bus.save_size, 32'd0);
        check({tag, "_sum"}, bus.save_checksum, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit got;
        int w0;
        int cnt;

        vecs[0] = '{26'h0000010, 64'h4444_3333_2222_1111, 8'hFF, 4, 32'h18};
        vecs[1] = '{26'h0000000, 64'h0123_4567_89AB_CDEF, 8'h0C, 1, 32'h18};
        vecs[2] = '{26'h0000100, 64'hDEAD_BEEF_CAFE_F00D, 8'h81, 2, 32'h108};
        vecs[3] = '{26'h0000040, 64'h1234_5678_9ABC_DEF0, 8'h00, 0, 32'h108};
        vecs[4] = '{26'h3FFFFF8, 64'h0000_5A5A_0000_0000, 8'h30, 1, 32'h0400_0000};
        vecs[5] = '{26'h000001F, 64'h0000_0000_0000_7777, 8'h03, 1, 32'h0400_0000};

        bus.savestate_start = 1'b0;
        bus.ss_din  = '0;
        bus.ss_addr = '0;
        bus.ss_rnw  = 1'b0;
        bus.ss_req  = 1'b0;
        bus.ss_be   = '0;
        bus.ss_busy = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        bus.ss_busy = 1'b1;
        repeat (2) @(negedge clk);

        // Session 1: table of write requests, then manager goes idle
        do_start();
        for (int i = 0; i < 6; i++) begin
            w0 = n_writes;
            send_req(vecs[i], got);
            check($sformatf("ack_seen_%0d", i), got, 1'b1);
            check($sformatf("save_size_%0d", i), bus.save_size, vecs[i].size);
            check($sformatf("write_count_%0d", i), n_writes - w0, vecs[i].nwr);
            check($sformatf("queue_drained_%0d", i), exp_q.size(), 0);
`ifdef SAVE_STATE_CHECKSUM_EN
            check($sformatf("checksum_%0d", i), bus.save_checksum, m_sum);
            if (i == 0) check("checksum_first", bus.save_checksum, 32'h0000_AAAA);
`else
            check($sformatf("checksum_%0d", i), bus.save_checksum, 32'd0);
`endif
            @(negedge clk);
            check($sformatf("ack_one_cycle_%0d", i), bus.ss_ack, 1'b0);
        end
        bus.ss_busy = 1'b0;
        wait_busy_low("finish_seen");
        check("finish_ok_err", {bus.savestate_start_ok, bus.savestate_start_err}, 2'b10);
        repeat (2) @(negedge clk);
        check("ok_sticky", {bus.savestate_start_ok, bus.save_size}, {1'b1, 32'h0400_0000});

        // Session 2: read request during save is an error
        bus.ss_busy = 1'b1;
        do_start();
        check("size_cleared", bus.save_size, 32'd0);
        w0 = n_writes;
        bus.ss_rnw = 1'b1;
        bus.ss_req = 1'b1;
        wait_busy_low("rnw_error_seen");
        bus.ss_req = 1'b0;
        bus.ss_rnw = 1'b0;
        check("rnw_ok_err", {bus.savestate_start_ok, bus.savestate_start_err}, 2'b01);
        check("rnw_no_write", n_writes - w0, 0);

        // Session 3: no manager activity -> timeout, then a fresh start clears err
        do_start();
        cnt = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.savestate_start_busy) break;
            cnt++;
        end
        check("timeout_cycles", cnt, c_TIMEOUT);
        check("timeout_err", {bus.savestate_start_ok, bus.savestate_start_err}, 2'b01);
        do_start();
        bus.ss_busy = 1'b0;
        wait_busy_low("finish_after_timeout");
        check("finish2_ok_err", {bus.savestate_start_ok, bus.savestate_start_err}, 2'b10);

        // Session 4: reset while a PSRAM write is outstanding
        bus.ss_busy = 1'b1;
        do_start();
        resp_en = 1'b0;
        bus.ss_addr = 26'h0000020;
        bus.ss_din  = 64'hFFFF_EEEE_DDDD_CCCC;
        bus.ss_be   = 8'hFF;
        bus.ss_req  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_write_en) begin
                got = 1'b1;
                break;
            end
        end
        check("write_pending", got, 1'b1);
        check("pending_addr", bus.mem_addr, 21'h000010);
        rst = 1'b1;
        #1;
        check("async_write_en_drop", bus.mem_write_en, 1'b0);
        check_all_zero("midsave_reset");
        bus.ss_req = 1'b0;
        bus.savestate_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {bus.savestate_start_busy, bus.ss_save, bus.mem_write_en}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/save_state_writer.md
Name: save_state_writer

Overview:
Save-direction companion to the save-state load controller, in the clk_ppu_21_47 domain. Handles the APF savestate_start handshake and pulses ss_save to the MiSTer savestate manager. Accepts its 64-bit write requests and splits each into up to four 16-bit PSRAM word writes through a req/done write port. The write port is synchronised to the PSRAM clock by the parent. Reports the saved image size so the bridge read path knows how many bytes to stream out.

Parameters:
SS_SAVE_PULSE_CYCLES, 4, cycles ss_save is held high after start is accepted
TIMEOUT_CYCLES, 2**20, idle cycles in WAIT_REQ, with no ss_req and no busy fall, before the save aborts with error

Ports:
clk_ppu_21_47  in  1  sole clock
reset  in  1  asynchronous, active-high
savestate_start  in  1  APF save request; rising edge starts a save
savestate_start_ack  out  1  one-cycle pulse when start is accepted
savestate_start_busy  out  1  high while a save is in progress
savestate_start_ok  out  1  sticky success flag
savestate_start_err  out  1  sticky error flag
ss_save  out  1  save command to the savestate manager
ss_din  in  64  write data from the manager
ss_addr  in  26  byte address, 8-byte aligned; bits [2:0] ignored
ss_rnw  in  1  1 = read request, illegal during save
ss_req  in  1  request strobe
ss_be  in  8  byte enables
ss_ack  out  1  one-cycle completion pulse
ss_busy  in  1  manager busy
mem_write_en  out  1  PSRAM write request, held until mem_write_done
mem_addr  out  21  16-bit word address
mem_data  out  16  write data
mem_write_high_byte  out  1  upper byte enable
mem_write_low_byte  out  1  lower byte enable
mem_write_done  in  1  one-cycle pulse: current write complete
save_size  out  32  bytes in image (high-water mark)
save_checksum  out  32  see Optional Feature

Behaviour:
- Reset (async, active-high): every output is 0 and state is IDLE. Registered edge-detect history (prev start, prev busy) resets to 0. Asserting reset mid-save drops mem_write_en immediately; no ack is issued for the in-flight request.
- States:
  - IDLE: on a savestate_start rising edge, go to ACK. Start edges in any other state are ignored.
  - ACK (1 cycle): savestate_start_ack=1; clear ok, err, save_size and checksum; set busy=1; set ss_save=1; go to PULSE.
  - PULSE: hold ss_save for SS_SAVE_PULSE_CYCLES total cycles counted from ACK, then ss_save=0 and go to WAIT_REQ.
  - WAIT_REQ: evaluated in this priority order:
    - ss_req with ss_rnw=1 -> ERROR.
    - ss_req with ss_rnw=0 -> latch ss_din, ss_addr and ss_be; set k=0; timeout counter=0; go to WORD.
    - ss_busy falling edge (prev_busy=1, ss_busy=0) -> FINISH.
    - Timeout counter reaches TIMEOUT_CYCLES-1 -> ERROR.
    - The counter increments only in WAIT_REQ.
  - WORD: word k uses be pair {be[2k+1], be[2k]}.
    - Pair is 00: skip the word and advance k without a write.
    - Otherwise: mem_addr={addr[21:3],k[1:0]}, mem_data=din[16k+15:16k], high_byte=be[2k+1], low_byte=be[2k]; mem_write_en=1; go to WAIT_DONE.
    - When k==3 is finished or skipped -> SEND.
  - WAIT_DONE: hold mem_write_en, addr, data and byte enables stable until mem_write_done=1. Then mem_write_en=0 for at least one cycle, k++, return to WORD (or SEND after k==3).
  - SEND (1 cycle): ss_ack=1; save_size=max(save_size, addr[25:3]*8+8); go to WAIT_REQ.
  - FINISH (1 cycle): busy=0, ok=1 -> IDLE.
  - ERROR (1 cycle): busy=0, err=1, mem_write_en=0 -> IDLE.
- A ss_req that falls while in WORD, WAIT_DONE or SEND is not re-sampled; the request is captured at WAIT_REQ entry only.
- A busy fall in the same cycle as ss_req: the request is served first. The busy fall is lost unless the manager idles; the timeout then ends the save with err. This is documented, not a bug.
- A mem_write_done outside WAIT_DONE is ignored.
- ok and err persist until the next accepted start.

Optional Feature:
SAVE_STATE_CHECKSUM_EN
- Defined: save_checksum is a 32-bit wrapping sum of the 16-bit mem_data values. Each value is zero-extended and added on the cycle its mem_write_done is taken. The sum is cleared in ACK.
- Undefined: save_checksum is constant 0 and no adder is synthesised.

Test Plan:
- Start edge, manager issues one req with addr=0x10, din=0x4444_3333_2222_1111, be=0xFF, done after 3 cycles each -> four writes to word addrs 8,9,10,11 with data 1111,2222,3333,4444; one ss_ack pulse; save_size=0x18.
- be=0x0C at addr 0 -> exactly one write, addr 1, high=1, low=1; words 0, 2 and 3 skipped; ss_ack follows.
- Two reqs, then ss_busy 1->0 -> busy falls, ok=1, err=0; ack pulses once per request; ss_save high for exactly 4 cycles.
- ss_req with ss_rnw=1 -> err=1, busy=0, no mem_write_en.
- No req or busy activity for TIMEOUT_CYCLES (set to 16 in sim) -> err=1 after 16 WAIT_REQ cycles; a second start edge then clears err and re-acks.
- reset pulsed during WAIT_DONE -> mem_write_en drops asynchronously; all outputs 0; with SAVE_STATE_CHECKSUM_EN, checksum after the first scenario is 0x0000_AAAA.
